// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator / test-flag writeback stage.
package acc_pkg;

  localparam int unsigned ACC_W   = 11;
  localparam int unsigned PC_W    = 4;
  localparam int unsigned ONCE_N  = 1 << PC_W;
  localparam int          SAT_MAX = 999;

  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpWralu = 3'd1,
    OpMovi  = 3'd2,
    OpTeq   = 3'd3,
    OpTgt   = 3'd4,
    OpTlt   = 3'd5,
    OpRsv6  = 3'd6,
    OpRsv7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CondAlways = 2'd0,
    CondPlus   = 2'd1,
    CondMinus  = 2'd2,
    CondOnce   = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    TestNone  = 2'd0,
    TestPlus  = 2'd1,
    TestMinus = 2'd2
  } test_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StCommit = 1'b1
  } state_e;

  // A test instruction sets PLUS when its selected compare flag is true, else MINUS.
  function automatic test_e test_from_flag(input logic flag);
    return flag ? TestPlus : TestMinus;
  endfunction

endpackage

// File: rtl/acc_unit_if.sv
// Decoder/ALU-facing bus of the accumulator stage. The master side is the decoder/ALU
// environment, the slave side is acc_unit.
interface acc_unit_if;

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [2:0]                     cmd_op;
  logic [1:0]                     cmd_cond;
  logic [acc_pkg::PC_W-1:0]       cmd_pc;
  logic [acc_pkg::ACC_W-1:0]      cmd_imm;
  logic [acc_pkg::ACC_W-1:0]      alu_out;
  logic                           alu_overflow;
  logic                           alu_gr;
  logic                           alu_le;
  logic                           alu_eq;
  logic                           once_clr;
  logic [acc_pkg::ACC_W-1:0]      acc;
  logic [1:0]                     test_state;
  logic                           skipped;
  logic                           sat;

  modport master (
    output cmd_valid, cmd_op, cmd_cond, cmd_pc, cmd_imm,
    output alu_out, alu_overflow, alu_gr, alu_le, alu_eq, once_clr,
    input  cmd_ready, acc, test_state, skipped, sat
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cond, cmd_pc, cmd_imm,
    input  alu_out, alu_overflow, alu_gr, alu_le, alu_eq, once_clr,
    output cmd_ready, acc, test_state, skipped, sat
  );

endinterface

// File: rtl/acc_saturate.sv
// Combinational clamp of a writeback value to -SAT_MAX..+SAT_MAX.
// On signed overflow the stored bit pattern has the wrong sign, so its MSB
// indicates the opposite of the true result's sign.
module acc_saturate
  import acc_pkg::*;
(
  input  logic [ACC_W-1:0] i_value,
  input  logic             i_overflow,
  output logic [ACC_W-1:0] o_value,
  output logic             o_sat
);

  localparam logic [ACC_W-1:0] SatPos = ACC_W'(SAT_MAX);
  localparam logic [ACC_W-1:0] SatNeg = ACC_W'(-SAT_MAX);

  logic signed [ACC_W-1:0] w_value_s;
  assign w_value_s = $signed(i_value);

  // Select the clamped result.
  always_comb begin
    o_value = i_value;
    if (i_overflow) begin
      o_value = i_value[ACC_W-1] ? SatPos : SatNeg;
    end else if (w_value_s > $signed(SatPos)) begin
      o_value = SatPos;
    end else if (w_value_s < $signed(SatNeg)) begin
      o_value = SatNeg;
    end
  end

  assign o_sat = i_overflow | (o_value != i_value);

endmodule

// File: rtl/acc_unit.sv
// Accumulator and test-flag writeback stage behind the ALU.
// Accepts one command in IDLE, commits it one cycle later in COMMIT.
// Build option: define ACC_SAT_EN to clamp writebacks to -999..999 and drive sat;
// without it writebacks wrap at 11 bits and sat stays 0.
module acc_unit
  import acc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  acc_unit_if.slave  bus
);

  state_e             r_state, w_state_d;
  logic               w_ready, w_accept, w_commit, w_exec;

  op_e                r_op;
  cond_e              r_cond;
  logic               r_exec;
  logic [PC_W-1:0]    r_pc;
  logic [ACC_W-1:0]   r_alu_out, r_imm;
  logic               r_gr, r_le, r_eq;

  logic [ACC_W-1:0]   r_acc, w_acc_d;
  test_e              r_test, w_test_d;
  logic [ONCE_N-1:0]  r_once_mask, w_once_mask_d;
  logic               r_skipped, w_skipped_d;

  logic [ACC_W-1:0]   w_wr_value, w_wr_result;
  logic               w_is_write;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: every accepted command spends exactly one cycle in COMMIT.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (bus.cmd_valid) w_state_d = StCommit;
      StCommit: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_ready  = (r_state == StIdle);
    w_accept = w_ready && bus.cmd_valid;
    w_commit = (r_state == StCommit);
  end

  // Condition evaluated against state as it stands at accept time.
  always_comb begin
    w_exec = 1'b1;
    case (cond_e'(bus.cmd_cond))
      CondAlways: w_exec = 1'b1;
      CondPlus:   w_exec = (r_test == TestPlus);
      CondMinus:  w_exec = (r_test == TestMinus);
      CondOnce:   w_exec = !r_once_mask[bus.cmd_pc];
      default:    w_exec = 1'b1;
    endcase
  end

  // Capture the command and ALU outputs at accept; later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= OpNop;
      r_cond    <= CondAlways;
      r_exec    <= 1'b0;
      r_pc      <= '0;
      r_alu_out <= '0;
      r_imm     <= '0;
      r_gr      <= 1'b0;
      r_le      <= 1'b0;
      r_eq      <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op_e'(bus.cmd_op);
      r_cond    <= cond_e'(bus.cmd_cond);
      r_exec    <= w_exec;
      r_pc      <= bus.cmd_pc;
      r_alu_out <= bus.alu_out;
      r_imm     <= bus.cmd_imm;
      r_gr      <= bus.alu_gr;
      r_le      <= bus.alu_le;
      r_eq      <= bus.alu_eq;
    end
  end

  // Writeback operand: ALU result for WRALU, immediate otherwise.
  always_comb begin
    w_is_write = (r_op == OpWralu) || (r_op == OpMovi);
    w_wr_value = (r_op == OpWralu) ? r_alu_out : r_imm;
  end

`ifdef ACC_SAT_EN
  logic r_ovf;
  logic w_wr_ovf, w_wr_sat;
  logic r_sat, w_sat_d;

  // Overflow is captured with the rest of the ALU outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= bus.alu_overflow;
    end
  end

  // Immediates never carry overflow.
  always_comb begin
    w_wr_ovf = (r_op == OpWralu) && r_ovf;
  end

  acc_saturate u_saturate (
    .i_value    (w_wr_value),
    .i_overflow (w_wr_ovf),
    .o_value    (w_wr_result),
    .o_sat      (w_wr_sat)
  );

  // sat pulses only for an executed write that was clamped.
  always_comb begin
    w_sat_d = w_commit && r_exec && w_is_write && w_wr_sat;
  end

  // sat pulse register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_d;
    end
  end

  assign bus.sat = r_sat;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = bus.alu_overflow;
  assign w_wr_result  = w_wr_value;
  assign bus.sat      = 1'b0;
`endif

  // Commit next-state: once_clr clears first so a same-cycle ONCE commit still sets its bit.
  always_comb begin
    w_acc_d       = r_acc;
    w_test_d      = r_test;
    w_once_mask_d = r_once_mask;
    w_skipped_d   = 1'b0;
    if (bus.once_clr) begin
      w_once_mask_d = '0;
    end
    if (w_commit) begin
      if (!r_exec) begin
        w_skipped_d = 1'b1;
      end else begin
        case (r_op)
          OpWralu, OpMovi: w_acc_d  = w_wr_result;
          OpTeq:           w_test_d = test_from_flag(r_eq);
          OpTgt:           w_test_d = test_from_flag(r_gr);
          OpTlt:           w_test_d = test_from_flag(r_le);
          default:         ;
        endcase
        if (r_cond == CondOnce) begin
          w_once_mask_d[r_pc] = 1'b1;
        end
      end
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_test      <= TestNone;
      r_once_mask <= '0;
      r_skipped   <= 1'b0;
    end else begin
      r_acc       <= w_acc_d;
      r_test      <= w_test_d;
      r_once_mask <= w_once_mask_d;
      r_skipped   <= w_skipped_d;
    end
  end

  assign bus.cmd_ready  = w_ready;
  assign bus.acc        = r_acc;
  assign bus.test_state = r_test;
  assign bus.skipped    = r_skipped;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit: directed cases plus randomized commands checked
// against an arithmetic reference model. Works with or without ACC_SAT_EN.
module tb_acc_unit;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  acc_unit_if bus ();

  acc_unit u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [10:0] acc;
    logic [1:0]  test;
    logic        skip;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic prev_ready = 1'b1;

  // Reference model state
  int         m_acc;
  int         m_test;   // 0 none, 1 plus, 2 minus
  logic [15:0] m_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural clamp rule, in plain integers.
  function automatic void clamp(input logic [10:0] v, input logic ovf, output int r, output bit s);
    int sv;
    sv = $signed(v);
`ifdef ACC_SAT_EN
    if (ovf) r = v[10] ? 999 : -999;
    else if (sv > 999) r = 999;
    else if (sv < -999) r = -999;
    else r = sv;
    s = ovf || (r != sv);
`else
    r = sv;
    s = 1'b0;
    if (ovf) r = sv;
`endif
  endfunction

  function automatic exp_t model(input int op, input int cond, input int pc,
                                 input logic [10:0] imm, input logic [10:0] alu,
                                 input logic ovf, input logic gr, input logic le,
                                 input logic eq, input bit clr);
    exp_t e;
    bit   ex;
    int   r;
    bit   s;
    ex = (cond == 0) || (cond == 1 && m_test == 1) || (cond == 2 && m_test == 2) ||
         (cond == 3 && !m_mask[pc]);
    e.skip = !ex;
    e.sat  = 1'b0;
    if (clr) m_mask = '0;
    if (ex) begin
      if (op == 1) begin clamp(alu, ovf, r, s); m_acc = r; e.sat = s; end
      else if (op == 2) begin clamp(imm, 1'b0, r, s); m_acc = r; e.sat = s; end
      else if (op == 3) m_test = eq ? 1 : 2;
      else if (op == 4) m_test = gr ? 1 : 2;
      else if (op == 5) m_test = le ? 1 : 2;
      if (cond == 3) m_mask[pc] = 1'b1;
    end
    e.acc  = m_acc[10:0];
    e.test = m_test[1:0];
    e.cyc  = 0;
    return e;
  endfunction

  task automatic drive(input int op, input int cond, input int pc, input logic [10:0] imm,
                       input logic [10:0] alu, input logic ovf, input logic gr,
                       input logic le, input logic eq);
    bus.cmd_op       = op[2:0];
    bus.cmd_cond     = cond[1:0];
    bus.cmd_pc       = pc[3:0];
    bus.cmd_imm      = imm;
    bus.alu_out      = alu;
    bus.alu_overflow = ovf;
    bus.alu_gr       = gr;
    bus.alu_le       = le;
    bus.alu_eq       = eq;
    bus.cmd_valid    = 1'b1;
  endtask

  // Issue one command, push its expected result, scramble inputs during COMMIT.
  task automatic send(input int op, input int cond, input int pc, input logic [10:0] imm,
                      input logic [10:0] alu, input logic ovf, input logic gr,
                      input logic le, input logic eq, input bit hold, input bit clr_commit);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      check("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
      return;
    end
    drive(op, cond, pc, imm, alu, ovf, gr, le, eq);
    e = model(op, cond, pc, imm, alu, ovf, gr, le, eq, clr_commit);
    @(posedge clk);
    #1;
    e.cyc = cyc;
    sb.push_back(e);
    bus.alu_out      = 11'($urandom);
    bus.cmd_imm      = 11'($urandom);
    bus.alu_overflow = 1'($urandom);
    bus.alu_gr       = 1'($urandom);
    bus.alu_le       = 1'($urandom);
    bus.alu_eq       = 1'($urandom);
    bus.cmd_op       = 3'($urandom);
    if (!hold) bus.cmd_valid = 1'b0;
    if (clr_commit) bus.once_clr = 1'b1;
    @(negedge clk);
    check("ready_low_in_commit", {31'd0, bus.cmd_ready}, 32'd0);
    if (clr_commit) begin
      @(posedge clk);
      #1;
      bus.once_clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.once_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.once_clr = 1'b0;
    m_mask = '0;
  endtask

  // Monitor: a rising cmd_ready marks a commit; pulses must be low at all other times.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset_n) begin
      if (bus.cmd_ready && !prev_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got commit expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("acc", {21'd0, bus.acc}, {21'd0, e.acc});
          check("test_state", {30'd0, bus.test_state}, {30'd0, e.test});
          check("skipped", {31'd0, bus.skipped}, {31'd0, e.skip});
          check("sat", {31'd0, bus.sat}, {31'd0, e.sat});
          check("commit_latency", cyc - e.cyc, 32'd1);
        end
      end else begin
        check("skipped_idle", {31'd0, bus.skipped}, 32'd0);
        check("sat_idle", {31'd0, bus.sat}, 32'd0);
      end
    end
    prev_ready = bus.cmd_ready;
  end

  initial begin
    int w;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_cond = '0; bus.cmd_pc = '0;
    bus.cmd_imm = '0; bus.alu_out = '0; bus.alu_overflow = 1'b0; bus.alu_gr = 1'b0;
    bus.alu_le = 1'b0; bus.alu_eq = 1'b0; bus.once_clr = 1'b0;
    m_acc = 0; m_test = 0; m_mask = '0;

    repeat (2) @(negedge clk);
    check("rst_acc", {21'd0, bus.acc}, 32'd0);
    check("rst_test", {30'd0, bus.test_state}, 32'd0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_skipped", {31'd0, bus.skipped}, 32'd0);
    check("rst_sat", {31'd0, bus.sat}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Conditional with no test state yet
    send(2, 1, 0, 11'd7, 11'd0, 0, 0, 0, 0, 0, 0);
    // Saturation cases
    send(1, 0, 0, 11'd0, 11'd1000, 0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 11'd0, 11'h400, 1, 0, 0, 0, 0, 0);
    send(1, 0, 0, 11'd0, 11'h7FB, 0, 0, 0, 0, 0, 0);
    send(2, 0, 0, 11'h400, 11'd0, 0, 0, 0, 0, 0, 0);
    // Test flag and conditions
    send(4, 0, 0, 11'd0, 11'd0, 0, 1, 0, 0, 0, 0);
    send(2, 1, 0, 11'd7, 11'd0, 0, 0, 0, 0, 0, 0);
    send(2, 2, 0, 11'd9, 11'd0, 0, 0, 0, 0, 0, 0);
    // Once-only
    send(2, 3, 2, 11'd3, 11'd0, 0, 0, 0, 0, 0, 0);
    send(2, 3, 2, 11'd3, 11'd0, 0, 0, 0, 0, 0, 0);
    pulse_clr();
    send(2, 3, 2, 11'd4, 11'd0, 0, 0, 0, 0, 0, 0);
    pulse_clr();
    send(2, 3, 5, 11'd1, 11'd0, 0, 0, 0, 0, 0, 0);
    send(2, 3, 2, 11'd6, 11'd0, 0, 0, 0, 0, 0, 1);
    send(2, 3, 2, 11'd8, 11'd0, 0, 0, 0, 0, 0, 0);
    send(2, 3, 5, 11'd2, 11'd0, 0, 0, 0, 0, 0, 0);
    // Back-to-back with cmd_valid held high
    send(1, 0, 0, 11'd0, 11'd11, 0, 0, 0, 0, 1, 0);
    send(1, 0, 0, 11'd0, 11'd22, 0, 0, 0, 0, 1, 0);
    send(1, 0, 0, 11'd0, 11'd33, 0, 0, 0, 0, 1, 0);
    send(1, 0, 0, 11'd0, 11'd44, 0, 0, 0, 0, 0, 0);
    // Establish a non-reset test state before the mid-commit reset
    send(3, 0, 0, 11'd0, 11'd0, 0, 0, 0, 0, 0, 0);

    // Reset during COMMIT of WRALU 500
    @(negedge clk);
    drive(1, 0, 0, 11'd0, 11'd500, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_acc", {21'd0, bus.acc}, 32'd0);
    check("midrst_test", {30'd0, bus.test_state}, 32'd0);
    check("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("midrst_skipped", {31'd0, bus.skipped}, 32'd0);
    m_acc = 0; m_test = 0; m_mask = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_acc", {21'd0, bus.acc}, 32'd0);
    mon_en = 1'b1;

    // Randomized commands
    for (int i = 0; i < 300; i++) begin
      logic [10:0] alu, imm;
      int op, cond;
      op   = $urandom_range(0, 7);
      cond = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 3);
      alu  = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom_range(0, 60) + 970);
      if ($urandom_range(0, 1) == 0) alu = -alu;
      imm  = 11'($urandom);
      if ($urandom_range(0, 15) == 0) pulse_clr();
      send(op, cond, $urandom_range(0, 3), imm, alu, 1'($urandom_range(0, 7) == 0),
           1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom_range(0, 15) == 0);
    end

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
